// File: rtl/add_slice_sequencer_if.sv
// Request/response bundle between issue logic and the slice sequencer.
// master = requester (drives operands), slave = sequencer (drives result and flags).
interface add_slice_sequencer_if #(
  parameter int W = 32
);
  logic         i_start;
  logic         i_op_sub;
  logic         i_use_carry;
  logic         i_c_flag;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_ready;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;
  logic         o_n;
  logic         o_z;
  logic         o_c;
  logic         o_v;

  modport master (
    output i_start, i_op_sub, i_use_carry, i_c_flag, i_a, i_b,
    input  o_ready, o_busy, o_done, o_result, o_n, o_z, o_c, o_v
  );

  modport slave (
    input  i_start, i_op_sub, i_use_carry, i_c_flag, i_a, i_b,
    output o_ready, o_busy, o_done, o_result, o_n, o_z, o_c, o_v
  );
endinterface

// File: rtl/add_slice_sequencer.sv
// W-bit ADD/SUB/ADC/SBC through one shared N-bit slice, LS slice first; o_done K edges after accept.
// Requests are taken only while o_ready (IDLE/DONE); a start during RUN is dropped, never queued.
module add_slice_sequencer #(
  parameter int W = 32,
  parameter int N = 8
) (
  input logic            i_clk,
  input logic            i_rst_n,
  add_slice_sequencer_if.slave bus
);
  localparam int K  = W / N;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   op_a, op_b, work, work_nxt;
  logic           carry_reg;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   result_q;
  logic           n_q, z_q, c_q, v_q;
  logic           accept, last;
  logic [N-1:0]   sl_a, sl_b, sl_sum;
  logic           sl_cout, sl_ovf;

  assign accept = bus.i_start && (state != RUN);
  assign last   = (cnt == CW'(K - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sl_a = op_a[cnt*N +: N];
    sl_b = op_b[cnt*N +: N];
  end

  // Merge the current slice into the partial sum so the final edge can publish the whole word.
  always_comb begin
    work_nxt = work;
    work_nxt[cnt*N +: N] = sl_sum;
  end

  NAdder #(.N(N)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_reg),
    .sum  (sl_sum),
    .cout (sl_cout),
    .ovf  (sl_ovf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      work      <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      result_q  <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1; SBC replaces the +1 with the current C flag.
      op_a      <= bus.i_a;
      op_b      <= bus.i_op_sub ? ~bus.i_b : bus.i_b;
      carry_reg <= bus.i_use_carry ? bus.i_c_flag : bus.i_op_sub;
      cnt       <= '0;
    end else if (state == RUN) begin
      work      <= work_nxt;
      carry_reg <= sl_cout;
      cnt       <= cnt + CW'(1);
      if (last) begin
        result_q <= work_nxt;
        n_q      <= work_nxt[W-1];
        z_q      <= (work_nxt == '0);
        c_q      <= sl_cout;
        v_q      <= sl_ovf;
      end
    end
  end

  assign bus.o_busy   = (state == RUN);
  assign bus.o_ready  = (state != RUN);
  assign bus.o_done   = (state == DONE);
  assign bus.o_result = result_q;
  assign bus.o_n      = n_q;
  assign bus.o_z      = z_q;
  assign bus.o_c      = c_q;
  assign bus.o_v      = v_q;
endmodule

// N-bit adder slice with carry-out and two's-complement overflow of this slice.
module NAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
endmodule
